// File: rtl/m_fetch_queue_pkg.sv
// Shared constants and the fetch-queue entry layout.
package m_fetch_queue_pkg;

  localparam logic [31:0] DEF_HALT_WORD = 32'h000f0033;
  localparam logic [31:0] NOP_WORD      = 32'h00000013;
  localparam logic [31:0] DEF_RESET_PC  = 32'h00000000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/m_fetch_fifo.sv
// Prefetch FIFO: registered storage, head read straight from the entry array,
// occupancy counted separately from the pointers so full and empty never alias.
module m_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

  assign w_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  // A push into a full FIFO is dropped rather than overwriting the head.
  assign w_push  = i_push & ~w_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;

  // Storage, pointers and occupancy; flush wins over any same-cycle push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The upstream credit scheme must never push into a full FIFO.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(i_push && !i_flush && w_full));

endmodule

// File: rtl/m_fetch_queue.sv
// Instruction-fetch front end: issues reads to a synchronous instruction
// memory under a credit limit, captures returned words into the prefetch
// FIFO, stops on the halt word and restarts on redirect.
module m_fetch_queue
  import m_fetch_queue_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] HALT_WORD = DEF_HALT_WORD,
  parameter int          AW        = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_redirect,
  input  logic [31:0]              i_redirect_pc,
  output logic                     o_imem_en,
  output logic [AW-1:0]            o_imem_addr,
  input  logic [31:0]              i_imem_data,
  output logic                     o_valid,
  output logic [31:0]              o_pc,
  output logic [31:0]              o_instr,
  input  logic                     i_ready,
  output logic                     o_halted,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0]  CREDIT_MAX = (CW+1)'(DEPTH);
  localparam logic [31:0]  PC_MASK    = 32'hFFFF_FFFC;
  localparam logic [31:0]  RESET_PC_W = RESET_PC & PC_MASK;

  logic [31:0]   r_pc;
  logic [31:0]   r_inflight_pc;
  logic          r_inflight;
  logic          r_halted;

  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [CW:0]   w_outstanding;
  fetch_entry_t  w_push_entry;
  fetch_entry_t  w_head;

  // Occupancy plus the read still in flight is the credit the FIFO must cover.
  assign w_outstanding = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
  // Read enable is held off while reset is asserted so memory sees no request.
  assign w_issue = ~rst & ~r_halted & ~i_redirect & (w_outstanding < CREDIT_MAX);
  assign w_push  = r_inflight & ~r_halted & ~i_redirect;
  assign w_pop   = ~w_empty & i_ready;

  assign w_push_entry = '{pc: r_inflight_pc, instr: i_imem_data};

  assign o_imem_en   = w_issue;
  assign o_imem_addr = r_pc[AW+1:2];
  assign o_valid     = ~w_empty;
  assign o_pc        = w_head.pc;
  assign o_instr     = w_head.instr;
  assign o_halted    = r_halted;
  assign o_count     = w_count;

  // Fetch pc, in-flight tracking and halt latch; redirect overrides everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC_W;
      r_inflight_pc <= '0;
      r_inflight    <= 1'b0;
      r_halted      <= 1'b0;
    end else if (i_redirect) begin
      r_pc       <= i_redirect_pc & PC_MASK;
      r_inflight <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc          <= r_pc + 32'd4;
        r_inflight_pc <= r_pc;
      end
      if (w_push && (i_imem_data == HALT_WORD)) r_halted <= 1'b1;
    end
  end

  m_fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_redirect),
    .i_data  (w_push_entry),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_m_fetch_queue.sv
// Directed bench for m_fetch_queue: a table of per-cycle stream vectors plus
// hand-written sequences for backpressure, redirects, halt and async reset.
module tb_m_fetch_queue;

  localparam logic [31:0] HALT = 32'h000f0033;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_imem_en;
  logic [11:0] o_imem_addr;
  logic [31:0] i_imem_data;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_instr;
  logic        i_ready;
  logic        o_halted;
  logic [2:0]  o_count;

  logic [31:0] mem [0:4095];
  logic [31:0] r_imem_q = 32'h0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        ready;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic [2:0]  ecnt;
    logic        een;
  } vec_t;

  vec_t vt [10];

  m_fetch_queue #(
    .DEPTH     (4),
    .RESET_PC  (32'h0),
    .HALT_WORD (32'h000f0033),
    .AW        (12)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_imem_en     (o_imem_en),
    .o_imem_addr   (o_imem_addr),
    .i_imem_data   (i_imem_data),
    .o_valid       (o_valid),
    .o_pc          (o_pc),
    .o_instr       (o_instr),
    .i_ready       (i_ready),
    .o_halted      (o_halted),
    .o_count       (o_count)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: data the cycle after the request.
  always @(posedge clk) if (o_imem_en) r_imem_q <= mem[o_imem_addr];
  assign i_imem_data = r_imem_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_ready = 1'b0;
    i_redirect = 1'b0;
    i_redirect_pc = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    logic [31:0] acc_pc [8];
    logic [31:0] acc_in [8];

    for (int a = 0; a < 4096; a++) mem[a] = 32'h100 + a;

    vt[0] = '{ready: 1'b1, ev: 1'b0, epc: 32'h0, einstr: 32'h0, ecnt: 3'd0, een: 1'b1};
    vt[1] = '{ready: 1'b1, ev: 1'b0, epc: 32'h0, einstr: 32'h0, ecnt: 3'd0, een: 1'b1};
    for (int k = 2; k < 10; k++)
      vt[k] = '{ready: 1'b1, ev: 1'b1, epc: 32'(4*(k-2)), einstr: 32'h100 + 32'(k-2),
                ecnt: 3'd1, een: 1'b1};

    // Reset state while rst is held
    rst = 1'b1; i_ready = 1'b0; i_redirect = 1'b0; i_redirect_pc = 32'h0;
    tick();
    check("rst_valid", {31'b0, o_valid}, 32'd0);
    check("rst_count", {29'b0, o_count}, 32'd0);
    check("rst_en", {31'b0, o_imem_en}, 32'd0);
    check("rst_pc", o_pc, 32'h0);
    check("rst_instr", o_instr, 32'h0);
    check("rst_halted", {31'b0, o_halted}, 32'd0);

    // Stream table
    do_reset();
    for (int k = 0; k < 10; k++) begin
      i_ready = vt[k].ready;
      #1;
      check("stream_valid", {31'b0, o_valid}, {31'b0, vt[k].ev});
      check("stream_pc", o_pc, vt[k].epc);
      check("stream_instr", o_instr, vt[k].einstr);
      check("stream_count", {29'b0, o_count}, {29'b0, vt[k].ecnt});
      check("stream_en", {31'b0, o_imem_en}, {31'b0, vt[k].een});
      tick();
    end

    // Backpressure: credits run out, then drain in order with no gap
    do_reset();
    for (int c = 0; c < 10; c++) begin
      #1;
      if (c >= 4) check("bp_en_off", {31'b0, o_imem_en}, 32'd0);
      tick();
    end
    check("bp_count_sat", {29'b0, o_count}, 32'd4);
    check("bp_head_pc", o_pc, 32'h0);
    check("bp_head_instr", o_instr, 32'h100);
    i_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("bp_drain_valid", {31'b0, o_valid}, 32'd1);
      check("bp_drain_instr", o_instr, 32'h100 + 32'(k));
      check("bp_drain_pc", o_pc, 32'(4*k));
      tick();
    end

    // Redirect with a read in flight, low pc bits ignored
    do_reset();
    i_ready = 1'b1;
    repeat (5) tick();
    check("rd_pre_pc", o_pc, 32'hC);
    i_redirect = 1'b1; i_redirect_pc = 32'h43;
    #1;
    check("rd_en_blocked", {31'b0, o_imem_en}, 32'd0);
    tick();
    i_redirect = 1'b0;
    #1;
    check("rd_valid0", {31'b0, o_valid}, 32'd0);
    check("rd_count0", {29'b0, o_count}, 32'd0);
    check("rd_addr", {20'b0, o_imem_addr}, 32'h10);
    tick();
    check("rd_valid1", {31'b0, o_valid}, 32'd0);
    tick();
    check("rd_new_pc", o_pc, 32'h40);
    check("rd_new_instr", o_instr, 32'h110);
    tick();
    check("rd_next_pc", o_pc, 32'h44);

    // Redirect colliding with pop and push at count 2
    do_reset();
    repeat (3) tick();
    check("col_count2", {29'b0, o_count}, 32'd2);
    i_ready = 1'b1; i_redirect = 1'b1; i_redirect_pc = 32'h80;
    tick();
    i_redirect = 1'b0;
    #1;
    check("col_count0", {29'b0, o_count}, 32'd0);
    check("col_valid0", {31'b0, o_valid}, 32'd0);
    tick();
    check("col_valid_gap", {31'b0, o_valid}, 32'd0);
    tick();
    check("col_pc", o_pc, 32'h80);
    check("col_instr", o_instr, 32'h120);

    // Back-to-back redirects, last wins, and pc wraps past 2^32
    i_redirect = 1'b1; i_redirect_pc = 32'h40;
    tick();
    i_redirect_pc = 32'hFFFF_FFFC;
    tick();
    i_redirect = 1'b0;
    #1;
    check("b2b_addr", {20'b0, o_imem_addr}, 32'hFFF);
    tick();
    tick();
    check("b2b_pc", o_pc, 32'hFFFF_FFFC);
    check("b2b_instr", o_instr, 32'h10FF);
    tick();
    check("wrap_pc", o_pc, 32'h0);
    check("wrap_instr", o_instr, 32'h100);

    // Halt on word 3
    mem[3] = HALT;
    do_reset();
    i_ready = 1'b1;
    n_acc = 0;
    for (int c = 0; c < 14; c++) begin
      #1;
      if (o_valid && i_ready) begin
        if (n_acc < 8) begin
          acc_pc[n_acc] = o_pc;
          acc_in[n_acc] = o_instr;
        end
        n_acc++;
      end
      tick();
    end
    check("halt_n_delivered", 32'(n_acc), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check("halt_pc", acc_pc[k], 32'(4*k));
      check("halt_instr", acc_in[k], (k == 3) ? HALT : 32'h100 + 32'(k));
    end
    check("halt_flag", {31'b0, o_halted}, 32'd1);
    check("halt_en", {31'b0, o_imem_en}, 32'd0);
    check("halt_valid", {31'b0, o_valid}, 32'd0);
    i_redirect = 1'b1; i_redirect_pc = 32'h20;
    tick();
    i_redirect = 1'b0;
    #1;
    check("halt_clear", {31'b0, o_halted}, 32'd0);
    check("halt_resume_en", {31'b0, o_imem_en}, 32'd1);
    tick();
    tick();
    check("halt_resume_pc", o_pc, 32'h20);
    check("halt_resume_instr", o_instr, 32'h108);
    mem[3] = 32'h103;

    // Async reset mid-operation
    do_reset();
    repeat (4) tick();
    check("ar_count3", {29'b0, o_count}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid", {31'b0, o_valid}, 32'd0);
    check("ar_count", {29'b0, o_count}, 32'd0);
    check("ar_halted", {31'b0, o_halted}, 32'd0);
    check("ar_en", {31'b0, o_imem_en}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("ar_first_addr", {20'b0, o_imem_addr}, 32'h0);
    check("ar_first_en", {31'b0, o_imem_en}, 32'd1);
    tick();
    check("ar_second_addr", {20'b0, o_imem_addr}, 32'h1);
    tick();
    check("ar_first_pc", o_pc, 32'h0);
    check("ar_first_instr", o_instr, 32'h100);
    check("ar_first_valid", {31'b0, o_valid}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/m_fetch_queue.md
Name: m_fetch_queue

Overview:
- Instruction-fetch front end with a small prefetch FIFO.
- Drives the synchronous instruction memory, captures the returned words, and presents {pc, instr} to the decode stage through a valid/ready handshake.
- Absorbs decode stalls without losing fetched words.
- Flushes cleanly on a redirect from the branch-resolution stage or the speculative-branch logic.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- RESET_PC, 32'h0, first fetch address after reset.
- HALT_WORD, 32'h000f0033, instruction that stops fetching.
- AW, 12, instruction-memory word-address width.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- i_redirect  in  1  flush and restart fetch at i_redirect_pc.
- i_redirect_pc  in  32  new fetch pc; bits [1:0] ignored.
- o_imem_en  out  1  read request this cycle.
- o_imem_addr  out  AW  word address, pc[AW+1:2].
- i_imem_data  in  32  read data, valid the cycle after the request.
- o_valid  out  1  FIFO head holds an instruction.
- o_pc  out  32  pc of the head entry.
- o_instr  out  32  instruction of the head entry.
- i_ready  in  1  decode accepts head (pop when o_valid & i_ready).
- o_halted  out  1  HALT_WORD has been captured; fetch stopped.
- o_count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async): pc=RESET_PC, FIFO empty, inflight=0, halted=0. Consequently o_valid=0, o_count=0, o_imem_en=0, o_pc=0, o_instr=0.
- issue = !halted & !i_redirect & (count + inflight < DEPTH). o_imem_en=issue and o_imem_addr=pc[AW+1:2] are combinational from registers and i_redirect.
- On issue: pc<=pc+4, inflight<=1, inflight_pc<=pc. If there is no issue, inflight<=0.
- Return: when inflight=1 and there is no redirect, push {inflight_pc, i_imem_data} at the next edge.
  - Returns arriving while halted=1 are dropped.
  - If the pushed word == HALT_WORD: the entry is pushed and halted<=1.
  - The word fetched in the same cycle as the halt return is dropped on the following cycle.
- Latency: issue edge E0, push at E1, o_valid=1 after E1. Steady-state throughput is 1 instruction/cycle with i_ready=1.
- Credit rule guarantees no push when full. Pushing when count==DEPTH is an assertion failure.
- Simultaneous push and pop: count unchanged, order preserved. Pop when empty is ignored.
- Redirect (highest priority) at the edge:
  - FIFO emptied, inflight cleared, pc<=i_redirect_pc, halted<=0.
  - Any same-cycle pop or push is discarded.
  - No issue in the redirect cycle; fetch from i_redirect_pc starts the next cycle, so the first new o_valid appears 2 edges after the redirect edge.
- Back-to-back redirects: the last one wins.
- Head outputs (o_pc, o_instr) are registered FIFO entries and stable while o_valid & !i_ready.
- Pointer wrap: read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is tracked separately so full and empty are unambiguous.
- pc wraps modulo 2^32. o_imem_addr uses only pc[AW+1:2].
- Reset asserted mid-operation: everything returns to reset values immediately and the in-flight read is forgotten. The first issue after deassertion is at RESET_PC.

Decomposition:
- Shared package: HALT_WORD, NOP_WORD (32'h00000013), RESET_PC default, and the typedef fetch_entry_t {pc[31:0], instr[31:0]}.
- One sub-module, m_fetch_fifo:
  - Parameterised on DEPTH and entry width.
  - Async reset; push/pop/flush inputs; registered head output; count output.
- m_fetch_queue holds the pc, inflight, halted and issue/credit logic.

Test Plan:
- Stream: reset, memory words 0..7 = 0x100+i, i_ready=1 → o_valid from cycle 2, o_pc 0,4,8,… one per cycle, o_instr 0x100,0x101,…
- Backpressure: i_ready=0 for 10 cycles → o_count saturates at 4, o_imem_en=0 while count+inflight=4. Release → words 0x100..0x107 in order with no gap or duplicate.
- Redirect with in-flight read: at cycle 5, i_redirect=1 with pc 0x40 → o_valid=0 next cycle, o_count=0, o_imem_en=0 in the redirect cycle. Next o_pc=0x40 two edges later; no pre-redirect word ever appears.
- Redirect colliding with pop and push (FIFO count 2, i_ready=1): → after the edge count=0 and the popped entry is not counted as accepted.
- Halt: word 3 = 0x000f0033 → entries pc 0..0xC delivered, o_halted=1, o_imem_en stays 0, word 4 never delivered. A later redirect to 0x20 clears o_halted and resumes.
- Async reset: assert rst between edges while count=3 → o_valid, o_count, o_halted go to 0 immediately. After release, the first o_imem_addr is 0.
